// File: rtl/pipe_latch_elastic.sv
// -----------------------------------------------------------------------------
// pipe_latch_elastic
//
// Elastic pipeline latch for one stage boundary. Carries a WIDTH-bit payload
// downstream through a main register and a one-entry skid register, so the
// upstream stage may register its ready without dropping a beat. The hazard
// unit's per-latch command can freeze the latch (STALL) or empty it (FLUSH).
// A saturating counter records how many cycles the latch sat stalled while
// holding data.
//
// Handshake: a beat moves across a port on a rising edge where both valid and
// ready are high. Valid never waits for ready. in_ready and out_valid depend
// only on registered occupancy and state_i, never on the other port's
// handshake.
//
// Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      synchronous active-high reset
//   state_i    in   2      00 NORMAL, 01 STALL, 10 FLUSH, 11 STALL
//   in_valid   in   1      upstream payload valid
//   in_ready   out  1      latch accepts the payload this cycle
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      payload presented downstream
//   out_ready  in   1      downstream accepts the payload
//   out_data   out  WIDTH  presented payload (main register)
//   stall_cnt  out  CNT_W  saturating count of stalled-while-occupied cycles
//   occupancy  out  2      debug view of the occupancy FSM (0 EMPTY, 1 ONE, 2 TWO)
// -----------------------------------------------------------------------------
module pipe_latch_elastic #(
    parameter int                WIDTH     = 32,
    parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
    parameter int                CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       state_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       occupancy
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    localparam logic [1:0] CMD_NORMAL = 2'b00;
    localparam logic [1:0] CMD_FLUSH  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       occ_q,  occ_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    logic cmd_normal;
    logic cmd_flush;
    logic cmd_stall;
    logic in_xfer;
    logic out_xfer;

    // STALL (01) and the reserved code 11 both have bit 0 set; FLUSH does not.
    assign cmd_normal = (state_i == CMD_NORMAL);
    assign cmd_flush  = (state_i == CMD_FLUSH);
    assign cmd_stall  = state_i[0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            occ_q  <= OCC_EMPTY;
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
            cnt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            main_q <= main_d;
            skid_q <= skid_d;
            cnt_q  <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        cnt_d  = cnt_q;

        if (cmd_flush) begin
            occ_d  = OCC_EMPTY;
            main_d = NOP_VALUE;
            skid_d = NOP_VALUE;
        end else if (cmd_normal) begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (in_xfer) begin
                        occ_d  = OCC_ONE;
                        main_d = in_data;
                    end
                end
                OCC_ONE: begin
                    if (in_xfer && out_xfer) begin
                        // Pass-through: the new beat replaces the departing
                        // one, so occupancy stays at ONE with no bubble.
                        main_d = in_data;
                    end else if (in_xfer) begin
                        occ_d  = OCC_TWO;
                        skid_d = in_data;
                    end else if (out_xfer) begin
                        // main keeps its stale value; out_valid hides it.
                        occ_d  = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (out_xfer) begin
                        occ_d  = OCC_ONE;
                        main_d = skid_q;
                    end
                end
                default: begin
                    occ_d = OCC_EMPTY;
                end
            endcase
        end

        if (cmd_stall && (occ_q != OCC_EMPTY) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (occ_q != OCC_TWO)   && cmd_normal;
        out_valid = (occ_q != OCC_EMPTY) && cmd_normal;
        in_xfer   = in_valid  && in_ready;
        out_xfer  = out_valid && out_ready;
    end

    assign out_data  = main_q;
    assign stall_cnt = cnt_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_latch_elastic.sv
module tb_pipe_latch_elastic;

    localparam logic [7:0] NOP = 8'hE7;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] state_i;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic        a_in_ready, a_out_valid;
    logic [7:0]  a_out_data;
    logic [15:0] a_stall_cnt;
    logic [1:0]  a_occ;

    logic        b_in_ready, b_out_valid;
    logic [7:0]  b_out_data;
    logic [1:0]  b_stall_cnt;
    logic [1:0]  b_occ;

    int n_checks = 0;
    int n_errors = 0;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    always #5 CLK = ~CLK;

    pipe_latch_elastic #(.WIDTH(8), .NOP_VALUE(NOP), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .state_i(state_i),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .stall_cnt(a_stall_cnt), .occupancy(a_occ)
    );

    pipe_latch_elastic #(.WIDTH(8), .NOP_VALUE(NOP), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RST(RST), .state_i(state_i),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall_cnt), .occupancy(b_occ)
    );

    // ------------------------------------------------------------------
    // Reference model: FIFO of held beats, the last value shown, counters
    // ------------------------------------------------------------------
    logic [7:0] exp_q[$];
    logic [7:0] stale;
    int         cnt_big;
    int         cnt_small;
    bit         model_ok = 0;

    // Values sampled mid-cycle by the driver, used by the table checks.
    logic        s_ir, s_ov;
    logic [7:0]  s_od;
    logic [15:0] s_cnt;
    logic [1:0]  s_cnt_b;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        stale     = NOP;
        cnt_big   = 0;
        cnt_small = 0;
    endtask

    task automatic model_edge(input logic [1:0] st, input logic iv, input logic [7:0] d,
                              input logic ordy, input logic rst);
        bit ox, ix;
        if (rst) begin
            model_reset();
        end else if (st == 2'b10) begin
            exp_q.delete();
            stale = NOP;
        end else if (st == 2'b00) begin
            ox = ordy && (exp_q.size() > 0);
            ix = iv && (exp_q.size() < 2);
            if (ox) void'(exp_q.pop_front());
            if (ix) exp_q.push_back(d);
        end else if (exp_q.size() > 0) begin
            cnt_big   = sat(cnt_big + 1, 65535);
            cnt_small = sat(cnt_small + 1, 3);
        end
        if (exp_q.size() > 0) stale = exp_q[0];
    endtask

    task automatic model_check(input logic [1:0] st);
        logic       e_ir, e_ov;
        logic [7:0] e_od;
        e_ir = (st == 2'b00) && (exp_q.size() < 2);
        e_ov = (st == 2'b00) && (exp_q.size() > 0);
        e_od = (exp_q.size() > 0) ? exp_q[0] : stale;
        chk("m_in_ready",  a_in_ready,  e_ir);
        chk("m_out_valid", a_out_valid, e_ov);
        chk("m_out_data",  a_out_data,  e_od);
        chk("m_stall_cnt", a_stall_cnt, cnt_big);
        chk("m_occupancy", a_occ,       exp_q.size());
        chk("m_sat_in_ready",  b_in_ready,  e_ir);
        chk("m_sat_out_valid", b_out_valid, e_ov);
        chk("m_sat_out_data",  b_out_data,  e_od);
        chk("m_sat_stall_cnt", b_stall_cnt, cnt_small);
    endtask

    // ------------------------------------------------------------------
    // Driver: apply inputs just after a rising edge, sample on the falling
    // edge, advance the model on the next rising edge.
    // ------------------------------------------------------------------
    task automatic cycle(input logic [1:0] st, input logic iv, input logic [7:0] d, input logic ordy);
        state_i   = st;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge CLK);
        s_ir    = a_in_ready;
        s_ov    = a_out_valid;
        s_od    = a_out_data;
        s_cnt   = a_stall_cnt;
        s_cnt_b = b_stall_cnt;
        if (model_ok) model_check(st);
        @(posedge CLK);
        model_edge(st, iv, d, ordy, RST);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        RST = 1'b1;
        for (int i = 0; i < cycles; i++) cycle(2'b00, 1'b0, 8'h00, 1'b0);
        RST = 1'b0;
        model_reset();
        model_ok = 1;
    endtask

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0] st;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] st, input logic iv, input logic [7:0] d,
                                input logic ordy, input logic e_ir, input logic e_ov,
                                input logic [7:0] e_od, input int e_cnt);
        vec_t v;
        v.st = st; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        RST = 1'b1; state_i = 2'b00; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        // Stream 1..4 with out_ready high
        tbl.push_back(mk(2'b00, 1, 8'h01, 1, 1, 0, NOP,   0));
        tbl.push_back(mk(2'b00, 1, 8'h02, 1, 1, 1, 8'h01, 0));
        tbl.push_back(mk(2'b00, 1, 8'h03, 1, 1, 1, 8'h02, 0));
        tbl.push_back(mk(2'b00, 1, 8'h04, 1, 1, 1, 8'h03, 0));
        tbl.push_back(mk(2'b00, 0, 8'h00, 1, 1, 1, 8'h04, 0));
        tbl.push_back(mk(2'b00, 0, 8'h00, 0, 1, 0, 8'h04, 0));
        // Backpressure into the skid, then drain
        tbl.push_back(mk(2'b00, 1, 8'h0A, 0, 1, 0, 8'h04, 0));
        tbl.push_back(mk(2'b00, 1, 8'h0B, 0, 1, 1, 8'h0A, 0));
        tbl.push_back(mk(2'b00, 1, 8'h0C, 0, 0, 1, 8'h0A, 0));
        tbl.push_back(mk(2'b00, 1, 8'h0C, 1, 0, 1, 8'h0A, 0));
        tbl.push_back(mk(2'b00, 0, 8'h00, 1, 1, 1, 8'h0B, 0));
        tbl.push_back(mk(2'b00, 0, 8'h00, 0, 1, 0, 8'h0B, 0));
        // Stall five cycles with 0x55 held
        tbl.push_back(mk(2'b00, 1, 8'h55, 0, 1, 0, 8'h0B, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(2'b01, 1, 8'h66, 1, 0, 0, 8'h55, i));
        tbl.push_back(mk(2'b00, 0, 8'h00, 1, 1, 1, 8'h55, 5));
        tbl.push_back(mk(2'b00, 0, 8'h00, 0, 1, 0, 8'h55, 5));
        // Flush with two entries held
        tbl.push_back(mk(2'b00, 1, 8'h11, 0, 1, 0, 8'h55, 5));
        tbl.push_back(mk(2'b00, 1, 8'h22, 0, 1, 1, 8'h11, 5));
        tbl.push_back(mk(2'b10, 1, 8'h33, 1, 0, 0, 8'h11, 5));
        tbl.push_back(mk(2'b00, 0, 8'h00, 1, 1, 0, NOP,   5));
        tbl.push_back(mk(2'b00, 0, 8'h00, 1, 1, 0, NOP,   5));
        // Code 11 behaves as STALL
        tbl.push_back(mk(2'b00, 1, 8'h77, 0, 1, 0, NOP,   5));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(2'b11, 1, 8'h88, 1, 0, 0, 8'h77, 5 + i));
        tbl.push_back(mk(2'b00, 0, 8'h00, 1, 1, 1, 8'h77, 11));
        tbl.push_back(mk(2'b00, 0, 8'h00, 0, 1, 0, 8'h77, 11));
        // Stall while empty does not count
        tbl.push_back(mk(2'b01, 0, 8'h00, 0, 0, 0, 8'h77, 11));
        tbl.push_back(mk(2'b00, 0, 8'h00, 0, 1, 0, 8'h77, 11));

        do_reset(2);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].st, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("tbl%0d_in_ready", i),  s_ir,    tbl[i].e_ir);
            chk($sformatf("tbl%0d_out_valid", i), s_ov,    tbl[i].e_ov);
            chk($sformatf("tbl%0d_out_data", i),  s_od,    tbl[i].e_od);
            chk($sformatf("tbl%0d_stall_cnt", i), s_cnt,   tbl[i].e_cnt);
            chk($sformatf("tbl%0d_sat_cnt", i),   s_cnt_b, sat(tbl[i].e_cnt, 3));
        end

        // Mid-operation reset while TWO and STALL
        cycle(2'b00, 1, 8'hC1, 0);
        cycle(2'b00, 1, 8'hC2, 0);
        cycle(2'b01, 1, 8'hC3, 1);
        chk("rst_pre_occ", a_occ, 2);
        RST = 1'b1;
        cycle(2'b01, 1, 8'hC4, 1);
        RST = 1'b0;
        cycle(2'b00, 0, 8'h00, 1);
        chk("rst_out_valid", s_ov,  1'b0);
        chk("rst_out_data",  s_od,  NOP);
        chk("rst_stall_cnt", s_cnt, 0);
        chk("rst_in_ready",  s_ir,  1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            int r;
            logic [1:0] st;
            r  = $urandom_range(0, 9);
            st = (r < 7) ? 2'b00 : (r == 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
            RST = ($urandom_range(0, 149) == 0);
            cycle(st, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            RST = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
